// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch_op encodings, fetch FSM states and
// the default fetch reset address.
package mips_pkg;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      ISSUE = 2'b10
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC select: jr target, taken beq/bne branch, or sequential.
module next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [1:0]  branch_op,
   input  logic        zero,
   input  logic [31:0] branch_offset,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic [31:0] npc
);

   logic        taken_s;
   logic [31:0] branch_tgt_s;

   assign branch_tgt_s = pc_plus4 + (branch_offset << 2);

   // Branch condition; the unused encoding 2'b11 behaves as no branch.
   always_comb begin
      taken_s = 1'b0;
      case (branch_op)
         BR_EQ:   taken_s = zero;
         BR_NE:   taken_s = ~zero;
         BR_NONE: taken_s = 1'b0;
         default: taken_s = 1'b0;
      endcase
   end

   // jr outranks any branch; its target is forced word-aligned.
   always_comb begin
      npc = pc_plus4;
      if (jr_en) begin
         npc = jr_target & 32'hFFFF_FFFC;
      end else if (taken_s) begin
         npc = branch_tgt_s;
      end else begin
         npc = pc_plus4;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the instruction to decode and advances the PC on retirement.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        instr_ready,
   input  logic [1:0]  branch_op,
   input  logic        zero,
   input  logic [31:0] branch_offset,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic        misalign,
   output logic [31:0] instr_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  count_q, count_d;
   logic         misalign_q, misalign_d;
   logic [31:0]  pc_plus4_s;
   logic [31:0]  npc_s;

   assign pc_plus4_s = pc_q + 32'd4;

   next_pc u_next_pc (
      .pc_plus4      (pc_plus4_s),
      .branch_op     (branch_op),
      .zero          (zero),
      .branch_offset (branch_offset),
      .jr_en         (jr_en),
      .jr_target     (jr_target),
      .npc           (npc_s)
   );

   // Next-state logic; ack only matters in FETCH, ready only in ISSUE.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      count_d    = count_q;
      misalign_d = misalign_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ISSUE;
            end else begin
               state_d = FETCH;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               pc_d       = npc_s;
               count_d    = count_q + 32'd1;
               misalign_d = misalign_q | (jr_en & (jr_target[1:0] != 2'b00));
               state_d    = FETCH;
            end else begin
               state_d = ISSUE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0000_0000;
         count_q    <= 32'h0000_0000;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ISSUE);
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_s;
   assign misalign    = misalign_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// instruction streams, checked against a transaction-level reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_ready;
   logic [1:0]  branch_op;
   logic        zero;
   logic [31:0] branch_offset;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        misalign;
   logic [31:0] instr_count;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_count;
   logic        m_mis;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .instr_ready   (instr_ready),
      .branch_op     (branch_op),
      .zero          (zero),
      .branch_offset (branch_offset),
      .jr_en         (jr_en),
      .jr_target     (jr_target),
      .misalign      (misalign),
      .instr_count   (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural next-PC rule, written as plain arithmetic.
   function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                           input logic z, input logic [31:0] off,
                                           input logic jr, input logic [31:0] tgt);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (jr) return tgt - (tgt % 32'd4);
      if ((op == 2'd1 && z) || (op == 2'd2 && !z)) return seq + off * 32'd4;
      return seq;
   endfunction

   task automatic expect_reset_state(input string tag);
      chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_pc"},    pc,                   32'h0000_0000);
      chk({tag, "_instr"}, instr,                32'h0000_0000);
      chk({tag, "_cnt"},   instr_count,          32'd0);
      chk({tag, "_mis"},   {31'd0, misalign},    32'd0);
   endtask

   // One full instruction: starts in a FETCH cycle, ends in the next FETCH cycle.
   task automatic run_instr(input int ack_dly, input int hold, input logic [31:0] word,
                            input logic [1:0] op, input logic z, input logic [31:0] off,
                            input logic jr, input logic [31:0] tgt);
      logic [31:0] held_instr;
      for (int i = 0; i < ack_dly; i++) begin
         chk("fetch_req",  {31'd0, imem_req},    32'd1);
         chk("fetch_addr", imem_addr,            m_pc);
         chk("fetch_vld",  {31'd0, instr_valid}, 32'd0);
         imem_ack    = 1'b0;
         instr_ready = 1'b1;
         tick();
      end
      chk("fetch_addr", imem_addr, m_pc);
      imem_ack    = 1'b1;
      imem_rdata  = word;
      instr_ready = 1'b0;
      tick();
      imem_ack = 1'b0;
      chk("issue_vld",   {31'd0, instr_valid}, 32'd1);
      chk("issue_req",   {31'd0, imem_req},    32'd0);
      chk("issue_instr", instr,                word);
      chk("issue_pc",    pc,                   m_pc);
      chk("issue_pc4",   pc_plus4,             m_pc + 32'd4);
      held_instr = instr;
      for (int i = 0; i < hold; i++) begin
         imem_ack      = 1'($urandom);
         imem_rdata    = $urandom;
         branch_op     = 2'($urandom);
         zero          = 1'($urandom);
         jr_en         = 1'($urandom);
         jr_target     = $urandom;
         tick();
         chk("hold_instr", instr,                held_instr);
         chk("hold_pc",    pc,                   m_pc);
         chk("hold_req",   {31'd0, imem_req},    32'd0);
         chk("hold_vld",   {31'd0, instr_valid}, 32'd1);
      end
      imem_ack      = 1'b0;
      instr_ready   = 1'b1;
      branch_op     = op;
      zero          = z;
      branch_offset = off;
      jr_en         = jr;
      jr_target     = tgt;
      tick();
      instr_ready = 1'b0;
      jr_en       = 1'b0;
      branch_op   = 2'b00;
      m_pc    = ref_npc(m_pc, op, z, off, jr, tgt);
      m_count = m_count + 32'd1;
      if (jr && (tgt % 32'd4 != 32'd0)) m_mis = 1'b1;
      chk("ret_pc",   pc,                   m_pc);
      chk("ret_cnt",  instr_count,          m_count);
      chk("ret_mis",  {31'd0, misalign},    {31'd0, m_mis});
      chk("ret_req",  {31'd0, imem_req},    32'd1);
      chk("ret_vld",  {31'd0, instr_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_pc = 32'h0; m_count = 32'h0; m_mis = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      branch_op = 2'b00; zero = 1'b0; branch_offset = 32'h0; jr_en = 1'b0; jr_target = 32'h0;
      tick();
      do_reset();
      expect_reset_state("rst");
      tick();
      chk("first_fetch_req", {31'd0, imem_req}, 32'd1);

      run_instr(3, 0, 32'h2008_0005, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
      run_instr(0, 0, $urandom, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
      run_instr(0, 0, $urandom, 2'b01, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
      run_instr(0, 0, $urandom, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0010);
      run_instr(1, 0, $urandom, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 32'h0);
      run_instr(0, 0, $urandom, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
      run_instr(0, 0, $urandom, 2'b10, 1'b0, 32'h0000_0003, 1'b0, 32'h0);
      run_instr(0, 0, $urandom, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
      run_instr(0, 0, $urandom, 2'b11, 1'b1, 32'h0000_0003, 1'b0, 32'h0);
      run_instr(0, 0, $urandom, 2'b01, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0103);
      run_instr(0, 0, $urandom, 2'b00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      run_instr(2, 5, $urandom, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

      for (int n = 0; n < 150; n++) begin
         run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                   2'($urandom), 1'($urandom), $urandom,
                   ($urandom_range(0, 7) == 0), $urandom);
      end

      // Reset in FETCH with a simultaneous ack; a further ack during IDLE is discarded.
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      do_reset();
      expect_reset_state("midrst");
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("restart_req",  {31'd0, imem_req},    32'd1);
      chk("restart_addr", imem_addr,            32'h0000_0000);
      chk("restart_vld",  {31'd0, instr_valid}, 32'd0);
      run_instr(0, 1, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

      // Reset while ISSUE has instr_ready asserted: reset wins.
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
      tick();
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      jr_en = 1'b1; jr_target = 32'h0000_0203;
      do_reset();
      instr_ready = 1'b0; jr_en = 1'b0;
      expect_reset_state("issrst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
